// File: rtl/clz_normalize.sv
// clz_normalize: two-stage valid/ready normalizer fed by a clz tree.
// Left-justifies the operand so its leading one lands at the mantissa MSB
// and reports the unbiased exponent (bit position of that leading one).
// Optional feature macro: CLZ_NORMALIZE_ROUND_EN (round-to-nearest-even on
// the discarded bits); when undefined the discarded bits are truncated.
module clz_normalize #(
    parameter int BITS_IN  = 16,
    parameter int BITS_OUT = 4,
    parameter int MANT_W   = 11,
    parameter int EXP_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS_IN-1:0]  in_data,
    input  logic [BITS_OUT-1:0] in_lz,
    input  logic                in_nz,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-1:0]   out_mant,
    output logic [EXP_W-1:0]    out_exp,
    output logic                out_zero
);

    // Stage-1 holding registers
    logic [BITS_IN-1:0]  s1_data_r;
    logic [BITS_OUT-1:0] s1_lz_r;
    logic                s1_nz_r;
    logic                s1_valid_r;

    // Handshake / datapath nets
    logic                s1_load_s;
    logic                s2_load_s;
    logic [BITS_IN-1:0]  shifted_s;
    logic [MANT_W-1:0]   trunc_mant_s;
    logic [EXP_W-1:0]    base_exp_s;
    logic [MANT_W-1:0]   round_mant_s;
    logic [EXP_W-1:0]    round_exp_s;
    logic [MANT_W-1:0]   next_mant_s;
    logic [EXP_W-1:0]    next_exp_s;
    logic                next_zero_s;

    // S2 refills whenever the output register is empty or being drained;
    // in_ready follows out_ready combinationally so a full pipe still streams.
    assign s2_load_s = s1_valid_r && (!out_valid || out_ready);
    assign in_ready  = !s1_valid_r || s2_load_s;
    assign s1_load_s = in_valid && in_ready;

    // Normalizing shift, truncated mantissa and unbiased exponent
    always_comb begin
        shifted_s    = s1_data_r << s1_lz_r;
        trunc_mant_s = shifted_s[BITS_IN-1 -: MANT_W];
        base_exp_s   = EXP_W'(BITS_IN - 1) - EXP_W'(s1_lz_r);
    end

`ifdef CLZ_NORMALIZE_ROUND_EN
    generate
        if (MANT_W < BITS_IN) begin : g_round
            localparam int DISC_W = BITS_IN - MANT_W;
            logic [DISC_W-1:0] disc_s;
            logic [DISC_W-1:0] below_guard_s;
            logic              guard_s;
            logic              sticky_s;
            logic              inc_s;
            logic [MANT_W:0]   sum_s;

            // Round-to-nearest-even; a carry-out renormalizes to 1.000.. and bumps exp
            always_comb begin
                disc_s        = shifted_s[DISC_W-1:0];
                guard_s       = disc_s[DISC_W-1];
                below_guard_s = disc_s << 1;
                sticky_s      = |below_guard_s;
                inc_s         = guard_s && (sticky_s || trunc_mant_s[0]);
                sum_s         = {1'b0, trunc_mant_s} + (MANT_W + 1)'(inc_s);
                if (sum_s[MANT_W]) begin
                    round_mant_s = {1'b1, {(MANT_W - 1){1'b0}}};
                    round_exp_s  = base_exp_s + EXP_W'(1);
                end else begin
                    round_mant_s = sum_s[MANT_W-1:0];
                    round_exp_s  = base_exp_s;
                end
            end
        end else begin : g_no_disc
            // Full-width mantissa: nothing is discarded, so nothing to round
            assign round_mant_s = trunc_mant_s;
            assign round_exp_s  = base_exp_s;
        end
    endgenerate
`else
    // Truncation: the bits below the mantissa are simply dropped
    logic unused_low_bits_s;
    assign unused_low_bits_s = ^shifted_s;
    assign round_mant_s      = trunc_mant_s;
    assign round_exp_s       = base_exp_s;
`endif

    // Zero operands bypass the shifter result (in_lz is meaningless for them)
    always_comb begin
        if (s1_nz_r) begin
            next_mant_s = round_mant_s;
            next_exp_s  = round_exp_s;
            next_zero_s = 1'b0;
        end else begin
            next_mant_s = {MANT_W{1'b0}};
            next_exp_s  = {EXP_W{1'b0}};
            next_zero_s = 1'b1;
        end
    end

    // Stage 1: capture the operand and its clz result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_r  <= {BITS_IN{1'b0}};
            s1_lz_r    <= {BITS_OUT{1'b0}};
            s1_nz_r    <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_data_r  <= in_data;
            s1_lz_r    <= in_lz;
            s1_nz_r    <= in_nz;
            s1_valid_r <= 1'b1;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mant  <= {MANT_W{1'b0}};
            out_exp   <= {EXP_W{1'b0}};
            out_zero  <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= 1'b1;
            out_mant  <= next_mant_s;
            out_exp   <= next_exp_s;
            out_zero  <= next_zero_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
